// File: rtl/ftdi_fifo_emu.sv
// ftdi_fifo_emu: device end of an FT245-style async FIFO bus, with an RX pattern source and a TX sink/checker.
// Optional host-jitter model on the RXF_n/TXE_n gaps is enabled by defining FTDI_EMU_STALL_EN.
module ftdi_fifo_emu #(
    parameter int DEPTH_LOG2       = 4,
    parameter int RX_BYTES         = 256,
    parameter int RXF_INACTIVE_CYC = 4,
    parameter int TXE_INACTIVE_CYC = 4,
    parameter int TX_DRAIN_CYC     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        iRX_EN,
    output logic        oFIFO_RXF_n,
    input  logic        iFIFO_RD_n,
    output logic [7:0]  oFIFO_DATA,
    output logic        oFIFO_TXE_n,
    input  logic        iFIFO_WR_n,
    input  logic [7:0]  iFIFO_DATA,
    output logic [15:0] oRX_COUNT,
    output logic [31:0] oTX_COUNT,
    output logic        oTX_ERR,
    output logic [7:0]  oTX_ERR_DATA,
    output logic        oPROTO_ERR
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [8:0] RX_GAP_LD = 9'(RXF_INACTIVE_CYC - 1);
    localparam logic [8:0] TX_GAP_LD = 9'(TXE_INACTIVE_CYC - 1);
    localparam logic [7:0] DRAIN_LAST = 8'(TX_DRAIN_CYC - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_READY, RX_DRIVE, RX_GAP} rx_state_t;
    typedef enum logic [1:0] {TX_READY, TX_BUSY, TX_GAP, TX_FULL} tx_state_t;

    rx_state_t rx_state;
    tx_state_t tx_state;
    logic [2:0] rd_sync, wr_sync;
    logic [7:0] dat_s1, dat_s2;
    logic rd_fall, rd_rise, wr_fall, wr_rise;
    logic [8:0] rx_gap, tx_gap;
    logic [2:0] jit;
    logic [7:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr, rptr;
    logic [DEPTH_LOG2:0] occ;
    logic full, empty, push, pop;
    logic [7:0] div, exp_byte, pop_byte;

    // Two-flop synchronisers on strobes and data, plus one extra strobe stage for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_sync <= 3'b111;
            wr_sync <= 3'b111;
            dat_s1  <= 8'h00;
            dat_s2  <= 8'h00;
        end else begin
            rd_sync <= {rd_sync[1:0], iFIFO_RD_n};
            wr_sync <= {wr_sync[1:0], iFIFO_WR_n};
            dat_s1  <= iFIFO_DATA;
            dat_s2  <= dat_s1;
        end
    end

    assign rd_fall = rd_sync[2] & ~rd_sync[1];
    assign rd_rise = ~rd_sync[2] & rd_sync[1];
    assign wr_fall = wr_sync[2] & ~wr_sync[1];
    assign wr_rise = ~wr_sync[2] & wr_sync[1];

`ifdef FTDI_EMU_STALL_EN
    logic [7:0] lfsr;

    // Free-running x^8+x^6+x^5+x^4+1 LFSR supplying 0..7 extra gap cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr <= 8'hA5;
        else lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign jit = lfsr[2:0];
`else
    assign jit = 3'd0;
`endif

    // RX source: offers one pattern byte per read strobe until RX_BYTES have been sourced
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state    <= RX_IDLE;
            oFIFO_RXF_n <= 1'b1;
            oFIFO_DATA  <= 8'h00;
            oRX_COUNT   <= 16'd0;
            rx_gap      <= 9'd0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (iRX_EN && oRX_COUNT < 16'(RX_BYTES)) begin
                        rx_state    <= RX_READY;
                        oFIFO_RXF_n <= 1'b0;
                    end
                end
                RX_READY: begin
                    if (rd_fall) begin
                        rx_state   <= RX_DRIVE;
                        oFIFO_DATA <= oRX_COUNT[7:0];
                    end
                end
                RX_DRIVE: begin
                    if (rd_rise) begin
                        rx_state    <= RX_GAP;
                        oFIFO_RXF_n <= 1'b1;
                        oFIFO_DATA  <= 8'h00;
                        oRX_COUNT   <= oRX_COUNT + 16'd1;
                        rx_gap      <= RX_GAP_LD + 9'(jit);
                    end
                end
                default: begin
                    if (rx_gap == 9'd0) rx_state <= RX_IDLE;
                    else rx_gap <= rx_gap - 9'd1;
                end
            endcase
        end
    end

    assign full  = occ == DEPTH_CNT;
    assign empty = occ == '0;
    assign push  = tx_state == TX_READY && wr_fall;
    assign pop   = !empty && div == DRAIN_LAST;
    assign pop_byte = mem[rptr];

    // TX sink handshake: one byte per write strobe, TXE_n held high through the gap and while full
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state    <= TX_FULL;
            oFIFO_TXE_n <= 1'b1;
            tx_gap      <= 9'd0;
        end else begin
            case (tx_state)
                TX_READY: begin
                    if (wr_fall) begin
                        tx_state    <= TX_BUSY;
                        oFIFO_TXE_n <= 1'b1;
                    end
                end
                TX_BUSY: begin
                    if (wr_rise) begin
                        tx_state <= TX_GAP;
                        tx_gap   <= TX_GAP_LD + 9'(jit);
                    end
                end
                TX_GAP: begin
                    if (tx_gap == 9'd0) begin
                        tx_state    <= full ? TX_FULL : TX_READY;
                        oFIFO_TXE_n <= full;
                    end else begin
                        tx_gap <= tx_gap - 9'd1;
                    end
                end
                default: begin
                    if (!full) begin
                        tx_state    <= TX_READY;
                        oFIFO_TXE_n <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Buffer storage needs no reset; occupancy tracks validity
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= dat_s2;
    end

    // Buffer pointers and occupancy; simultaneous push and pop leave occupancy unchanged
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
            occ  <= '0;
        end else begin
            wptr <= push ? wptr + 1'b1 : wptr;
            rptr <= pop ? rptr + 1'b1 : rptr;
            occ  <= occ + (DEPTH_LOG2 + 1)'(push) - (DEPTH_LOG2 + 1)'(pop);
        end
    end

    // Drain divider: restarts whenever the buffer is empty or a byte is popped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) div <= 8'd0;
        else div <= (empty || pop) ? 8'd0 : div + 8'd1;
    end

    // Pattern checker resyncs to each popped byte so one bad byte yields one mismatch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_byte     <= 8'h00;
            oTX_COUNT    <= 32'd0;
            oTX_ERR      <= 1'b0;
            oTX_ERR_DATA <= 8'h00;
        end else if (pop) begin
            exp_byte  <= pop_byte + 8'd1;
            oTX_COUNT <= oTX_COUNT + 32'd1;
            if (!oTX_ERR && pop_byte != exp_byte) begin
                oTX_ERR      <= 1'b1;
                oTX_ERR_DATA <= pop_byte;
            end
        end
    end

    // Sticky flag for a strobe issued while its flag says the device is not ready
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) oPROTO_ERR <= 1'b0;
        else if ((rd_fall && oFIFO_RXF_n) || (wr_fall && oFIFO_TXE_n)) oPROTO_ERR <= 1'b1;
    end
endmodule

// File: tb/tb_ftdi_fifo_emu.sv
// tb_ftdi_fifo_emu: directed bench for ftdi_fifo_emu (default build plus a slow-drain instance for the full case).
module tb_ftdi_fifo_emu;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rx_en = 1'b0;
    logic rd_n = 1'b1, wr_n = 1'b1, wr_n_f = 1'b1;
    logic [7:0] wdata = 8'h00, wdata_f = 8'h00;
    logic rxf_n, txe_n, tx_err, proto_err;
    logic rxf_n_f, txe_n_f, tx_err_f, proto_err_f;
    logic [7:0] rdata, tx_err_data, rdata_f, tx_err_data_f;
    logic [15:0] rx_count, rx_count_f;
    logic [31:0] tx_count, tx_count_f;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ftdi_fifo_emu dut (
        .clk(clk), .rst(rst), .iRX_EN(rx_en),
        .oFIFO_RXF_n(rxf_n), .iFIFO_RD_n(rd_n), .oFIFO_DATA(rdata),
        .oFIFO_TXE_n(txe_n), .iFIFO_WR_n(wr_n), .iFIFO_DATA(wdata),
        .oRX_COUNT(rx_count), .oTX_COUNT(tx_count), .oTX_ERR(tx_err),
        .oTX_ERR_DATA(tx_err_data), .oPROTO_ERR(proto_err)
    );

    ftdi_fifo_emu #(.TX_DRAIN_CYC(255)) dut_f (
        .clk(clk), .rst(rst), .iRX_EN(1'b0),
        .oFIFO_RXF_n(rxf_n_f), .iFIFO_RD_n(1'b1), .oFIFO_DATA(rdata_f),
        .oFIFO_TXE_n(txe_n_f), .iFIFO_WR_n(wr_n_f), .iFIFO_DATA(wdata_f),
        .oRX_COUNT(rx_count_f), .oTX_COUNT(tx_count_f), .oTX_ERR(tx_err_f),
        .oTX_ERR_DATA(tx_err_data_f), .oPROTO_ERR(proto_err_f)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic read_byte(output logic [7:0] b);
        int n;
        n = 0;
        while (rxf_n !== 1'b0 && n < 100) begin tick(1); n++; end
        chk("rxf_wait", 32'(rxf_n), 32'd0);
        rd_n = 1'b0;
        tick(6);
        b = rdata;
        rd_n = 1'b1;
        tick(4);
    endtask

    task automatic write_byte(input bit f, input logic [7:0] b);
        int n;
        n = 0;
        while ((f ? txe_n_f : txe_n) !== 1'b0 && n < 100) begin tick(1); n++; end
        chk("txe_wait", 32'(f ? txe_n_f : txe_n), 32'd0);
        if (f) begin wdata_f = b; wr_n_f = 1'b0; end
        else begin wdata = b; wr_n = 1'b0; end
        tick(5);
        if (f) wr_n_f = 1'b1;
        else wr_n = 1'b1;
    endtask

    initial begin
        logic [7:0] b;
        int n;
        // reset held with strobes toggling
        tick(1);
        for (int i = 0; i < 4; i++) begin rd_n = ~rd_n; wr_n = ~wr_n; tick(1); end
        rd_n = 1'b1; wr_n = 1'b1;
        tick(2);
        chk("rst_rxf", 32'(rxf_n), 32'd1);
        chk("rst_txe", 32'(txe_n), 32'd1);
        chk("rst_data", 32'(rdata), 32'd0);
        chk("rst_rxcnt", 32'(rx_count), 32'd0);
        chk("rst_txcnt", tx_count, 32'd0);
        chk("rst_err", 32'(tx_err), 32'd0);
        chk("rst_errdata", 32'(tx_err_data), 32'd0);
        chk("rst_proto", 32'(proto_err), 32'd0);
        rst = 1'b1;
        #1;
        chk("txe_at_release", 32'(txe_n), 32'd1);
        tick(1);
        chk("txe_1cyc", 32'(txe_n), 32'd0);
        chk("txe_f_1cyc", 32'(txe_n_f), 32'd0);
        // full RX pattern
        rx_en = 1'b1;
        for (int i = 0; i < 256; i++) begin
            read_byte(b);
            chk("rx_byte", 32'(b), 32'(i[7:0]));
        end
        chk("rx_count_256", 32'(rx_count), 32'd256);
        tick(30);
        chk("rxf_after_end", 32'(rxf_n), 32'd1);
        chk("rx_proto", 32'(proto_err), 32'd0);
        // reset mid RX_DRIVE at byte 0x10
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(2);
        for (int i = 0; i < 16; i++) read_byte(b);
        chk("rx_byte_0f", 32'(b), 32'h0F);
        n = 0;
        while (rxf_n !== 1'b0 && n < 100) begin tick(1); n++; end
        rd_n = 1'b0;
        tick(6);
        chk("drive_10", 32'(rdata), 32'h10);
        chk("drive_rxf", 32'(rxf_n), 32'd0);
        rst = 1'b0;
        #1;
        chk("mid_rst_rxf", 32'(rxf_n), 32'd1);
        chk("mid_rst_data", 32'(rdata), 32'd0);
        chk("mid_rst_rxcnt", 32'(rx_count), 32'd0);
        chk("mid_rst_txe", 32'(txe_n), 32'd1);
        chk("mid_rst_proto", 32'(proto_err), 32'd0);
        rd_n = 1'b1;
        tick(2);
        rst = 1'b1;
        read_byte(b);
        chk("after_rst_byte", 32'(b), 32'h00);
        chk("after_rst_rxcnt", 32'(rx_count), 32'd1);
        // TX pattern loops
        for (int l = 0; l < 4; l++)
            for (int i = 0; i < 256; i++) write_byte(1'b0, 8'(i));
        n = 0;
        while (tx_count !== 32'd1024 && n < 500) begin tick(1); n++; end
        chk("tx_count_1024", tx_count, 32'd1024);
        chk("tx_err_clean", 32'(tx_err), 32'd0);
        chk("tx_proto_clean", 32'(proto_err), 32'd0);
        // single bad byte
        write_byte(1'b0, 8'h00);
        write_byte(1'b0, 8'h01);
        write_byte(1'b0, 8'h05);
        write_byte(1'b0, 8'h06);
        n = 0;
        while (tx_count !== 32'd1028 && n < 500) begin tick(1); n++; end
        tick(20);
        chk("mm_count", tx_count, 32'd1028);
        chk("mm_err", 32'(tx_err), 32'd1);
        chk("mm_errdata", 32'(tx_err_data), 32'h05);
        // slow drain: fill buffer, then strobe while full
        for (int i = 0; i < 16; i++) write_byte(1'b1, 8'(i));
        tick(10);
        chk("full_txe", 32'(txe_n_f), 32'd1);
        chk("full_count", tx_count_f, 32'd0);
        chk("full_proto0", 32'(proto_err_f), 32'd0);
        wdata_f = 8'h55;
        wr_n_f = 1'b0;
        tick(5);
        wr_n_f = 1'b1;
        tick(5);
        chk("forced_proto", 32'(proto_err_f), 32'd1);
        chk("forced_txe", 32'(txe_n_f), 32'd1);
        n = 0;
        while (txe_n_f !== 1'b0 && n < 400) begin tick(1); n++; end
        chk("full_release_txe", 32'(txe_n_f), 32'd0);
        chk("full_release_cnt", tx_count_f, 32'd1);
        n = 0;
        while (tx_count_f !== 32'd16 && n < 5000) begin tick(1); n++; end
        tick(300);
        chk("full_drain_cnt", tx_count_f, 32'd16);
        chk("full_drain_err", 32'(tx_err_f), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
